alu_writeback: RTL

Result writeback stage directly downstream of the ALU. It captures each completed ALU result (dst low word, dst_h high word, command, destination address) when the ALU signals completion, and buffers it in a small FIFO. It then writes the result to memory over the shared bus using request/grant and write/ack handshakes. Two-word results (MUL, DIV) are written as two consecutive bus writes.

---
 rtl/alu_writeback.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// Result writeback stage: buffers completed ALU results in a small FIFO and
// writes each one to memory over the shared bus (two writes for MUL/DIV).
module alu_writeback #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 32,
    parameter int          DEPTH   = 2,
    parameter int          TIMEOUT = 16,
    parameter logic [3:0]  CMD_MUL = 4'h2,
    parameter logic [3:0]  CMD_DIV = 4'h3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [31:0]       command,
    input  logic [DATA_W-1:0] dst,
    input  logic [DATA_W-1:0] dst_h,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_wr,
    input  logic              bus_ack,
    output logic              wb_done,
    output logic              wb_err,
    output logic              wb_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WR_LO = 3'd2,
        S_WR_HI = 3'd3,
        S_REL   = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    function automatic logic is_two_word(input logic [3:0] code);
        return (code == CMD_MUL) || (code == CMD_DIV);
    endfunction

    logic [3:0]        mem_code [0:DEPTH-1];
    logic [DATA_W-1:0] mem_lo   [0:DEPTH-1];
    logic [DATA_W-1:0] mem_hi   [0:DEPTH-1];
    logic [ADDR_W-1:0] mem_addr [0:DEPTH-1];

    state_t            state_r, next_state_s;
    logic [CNT_W-1:0]  count_r, next_count_s;
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [TMO_W-1:0]  tmo_r;
    logic              bus_req_r, bus_wr_r, wb_done_r, wb_err_r, wb_busy_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic [DATA_W-1:0] bus_data_r;
    logic              push_s, pop_s, head_two_s, tmo_hit_s, in_wr_s;
    logic              unused_cmd_s;

    assign res_ready    = !rst && (count_r < FULL_CNT);
    assign push_s       = res_valid && res_ready;
    assign pop_s        = (state_r == S_REL) || (state_r == S_ABORT);
    assign head_two_s   = is_two_word(mem_code[rd_ptr_r]);
    assign tmo_hit_s    = (tmo_r == TMO_LAST);
    assign in_wr_s      = (state_r == S_WR_LO) || (state_r == S_WR_HI);
    assign unused_cmd_s = ^command[27:0];

    assign bus_req  = bus_req_r;
    assign bus_wr   = bus_wr_r;
    assign bus_addr = bus_addr_r;
    assign bus_data = bus_data_r;
    assign wb_done  = wb_done_r;
    assign wb_err   = wb_err_r;
    assign wb_busy  = wb_busy_r;

    // Next-state logic; IDLE also reacts to an incoming push to save a cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if ((count_r != ZERO_CNT) || push_s) next_state_s = S_REQ;
                else                                 next_state_s = S_IDLE;
            end
            S_REQ: begin
                if (bus_grant) next_state_s = S_WR_LO;
                else           next_state_s = S_REQ;
            end
            S_WR_LO: begin
                if (bus_ack)        next_state_s = head_two_s ? S_WR_HI : S_REL;
                else if (tmo_hit_s) next_state_s = S_ABORT;
                else                next_state_s = S_WR_LO;
            end
            S_WR_HI: begin
                if (bus_ack)        next_state_s = S_REL;
                else if (tmo_hit_s) next_state_s = S_ABORT;
                else                next_state_s = S_WR_HI;
            end
            S_REL:   next_state_s = S_IDLE;
            S_ABORT: next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // FIFO occupancy update for push/pop combinations.
    always_comb begin
        next_count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   next_count_s = count_r + CNT_W'(1);
            2'b01:   next_count_s = count_r - CNT_W'(1);
            default: next_count_s = count_r;
        endcase
    end

    // FIFO storage; contents are don't-care while the entry is not valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_code[wr_ptr_r] <= command[31:28];
            mem_lo[wr_ptr_r]   <= dst;
            mem_hi[wr_ptr_r]   <= dst_h;
            mem_addr[wr_ptr_r] <= dst_addr;
        end
    end

    // Control state, pointers, timeout counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            count_r    <= ZERO_CNT;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            tmo_r      <= {TMO_W{1'b0}};
            bus_req_r  <= 1'b0;
            bus_wr_r   <= 1'b0;
            bus_addr_r <= {ADDR_W{1'b0}};
            bus_data_r <= {DATA_W{1'b0}};
            wb_done_r  <= 1'b0;
            wb_err_r   <= 1'b0;
            wb_busy_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= next_count_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);

            // Counter restarts on every entry into a write state.
            if (in_wr_s && (next_state_s == state_r)) tmo_r <= tmo_r + TMO_W'(1);
            else                                      tmo_r <= {TMO_W{1'b0}};

            bus_req_r <= (next_state_s == S_REQ) || (next_state_s == S_WR_LO) ||
                         (next_state_s == S_WR_HI);
            bus_wr_r  <= (next_state_s == S_WR_LO) || (next_state_s == S_WR_HI);

            if ((state_r == S_REQ) && (next_state_s == S_WR_LO)) begin
                bus_addr_r <= mem_addr[rd_ptr_r];
                bus_data_r <= mem_lo[rd_ptr_r];
            end else if ((state_r == S_WR_LO) && (next_state_s == S_WR_HI)) begin
                bus_addr_r <= mem_addr[rd_ptr_r] + ADDR_W'(1);
                bus_data_r <= mem_hi[rd_ptr_r];
            end

            wb_done_r <= (next_state_s == S_REL);
            wb_err_r  <= (next_state_s == S_ABORT);
            wb_busy_r <= (next_count_s != ZERO_CNT) || (next_state_s != S_IDLE);
        end
    end

endmodule
